// File: rtl/vga_tile_pkg.sv
// Shared timing defaults, page-base table helper and pipeline types for the
// tile-map VGA scanner.
package vga_tile_pkg;

  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_SYNC_POL    = 0;
  localparam int DEF_TILE_SHIFT  = 3;
  localparam int DEF_MAP_COLS    = 80;
  localparam int DEF_ADDR_W      = 14;
  localparam int DEF_PAGE_W      = 1;
  localparam int DEF_PAGE_BASE   = 2048;
  localparam int DEF_PAGE_STRIDE = 4800;
  localparam int DEF_RD_LAT      = 1;
  localparam int DEF_COLOR_W     = 12;

  typedef logic [DEF_COLOR_W-1:0] color_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } pipe_stage_t;

  // Only ever evaluated on constants, so it folds into a table at elaboration.
  function automatic int unsigned page_base(input int unsigned base,
                                            input int unsigned stride,
                                            input int unsigned page);
    return base + page * stride;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the tile scanner: raw sync, visible flag, visible
// coordinates and frame markers, all derived from the current counter state.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       raw_hs,
  output logic       raw_vs,
  output logic       vis,
  output logic [9:0] x_ptr,
  output logic [9:0] y_ptr,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_origin
);

  localparam int H_TOT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOT - 1);
  localparam logic [10:0] H_SYNC_E = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_E = 11'(V_SYNC);
  localparam logic [10:0] H_VIS_S  = 11'(H_SYNC + H_BP);
  localparam logic [10:0] V_VIS_S  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] H_VIS_E  = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_VIS_E  = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic        POL      = 1'(SYNC_POL);

  logic [9:0]  cnt_x, cnt_y;
  logic [10:0] cx, cy;
  logic        h_wrap, h_vis, v_vis;

  assign cx = {1'b0, cnt_x};
  assign cy = {1'b0, cnt_y};

  assign h_wrap       = (cx == H_LAST);
  assign frame_end    = h_wrap && (cy == V_LAST);
  assign frame_origin = (cnt_x == '0) && (cnt_y == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_x       <= '0;
      cnt_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
      if (h_wrap) begin
        cnt_x <= '0;
        cnt_y <= (cy == V_LAST) ? '0 : cnt_y + 10'd1;
      end else begin
        cnt_x <= cnt_x + 10'd1;
      end
    end
  end

  // Window XNOR polarity: low inside the window when SYNC_POL = 0.
  assign raw_hs = (cx < H_SYNC_E) ~^ POL;
  assign raw_vs = (cy < V_SYNC_E) ~^ POL;

  assign h_vis = (cx >= H_VIS_S) && (cx < H_VIS_E);
  assign v_vis = (cy >= V_VIS_S) && (cy < V_VIS_E);
  assign vis   = h_vis && v_vis;

  assign x_ptr = vis ? 10'(cx - H_VIS_S) : '0;
  assign y_ptr = vis ? 10'(cy - V_VIS_S) : '0;

endmodule

// File: rtl/vga_tile_scanner.sv
// Tile-map VGA scanner: builds the video RAM read address incrementally from a
// paged tile map and re-aligns sync/blank with the returning colour data.
module vga_tile_scanner
  import vga_tile_pkg::*;
#(
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int SYNC_POL    = DEF_SYNC_POL,
  parameter int TILE_SHIFT  = DEF_TILE_SHIFT,
  parameter int MAP_COLS    = DEF_MAP_COLS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int PAGE_W      = DEF_PAGE_W,
  parameter int PAGE_BASE   = DEF_PAGE_BASE,
  parameter int PAGE_STRIDE = DEF_PAGE_STRIDE,
  parameter int RD_LAT      = DEF_RD_LAT,
  parameter int COLOR_W     = DEF_COLOR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PAGE_W-1:0]    page_req,
  input  logic                 page_req_vld,
  input  logic [COLOR_W-1:0]   color,
  output logic [ADDR_W-1:0]    addrb,
  output logic                 hs,
  output logic                 vs,
  output logic [COLOR_W/3-1:0] red,
  output logic [COLOR_W/3-1:0] green,
  output logic [COLOR_W/3-1:0] blue,
  output logic [9:0]           x_ptr,
  output logic [9:0]           y_ptr,
  output logic                 active,
  output logic                 frame_start,
  output logic [PAGE_W-1:0]    cur_page
);

  localparam int          NUM_PAGES = 2 ** PAGE_W;
  localparam int          C3        = COLOR_W / 3;
  localparam logic        POL       = 1'(SYNC_POL);
  localparam pipe_stage_t RST_STAGE = '{hs: POL, vs: POL, vis: 1'b0};

  logic raw_hs, raw_vs, vis, frame_end, frame_origin;

  vga_timing_gen #(
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .H_ACTIVE(H_ACTIVE),
    .H_FP    (H_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .V_ACTIVE(V_ACTIVE),
    .V_FP    (V_FP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .raw_hs      (raw_hs),
    .raw_vs      (raw_vs),
    .vis         (vis),
    .x_ptr       (x_ptr),
    .y_ptr       (y_ptr),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .frame_origin(frame_origin)
  );

  logic [ADDR_W-1:0] page_tbl [NUM_PAGES];

  for (genvar p = 0; p < NUM_PAGES; p++) begin : g_page_tbl
    assign page_tbl[p] = ADDR_W'(page_base(PAGE_BASE, PAGE_STRIDE, p));
  end

  logic [PAGE_W-1:0] pend_page;
  logic              pend_flag;

  // A strobe on the last frame clock bypasses the pending slot.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_page  <= '0;
      pend_page <= '0;
      pend_flag <= 1'b0;
    end else if (frame_end) begin
      pend_flag <= 1'b0;
      if (page_req_vld)
        cur_page <= page_req;
      else if (pend_flag)
        cur_page <= pend_page;
    end else if (page_req_vld) begin
      pend_page <= page_req;
      pend_flag <= 1'b1;
    end
  end

  logic [ADDR_W-1:0] row_base;
  logic              row_step;

  assign row_step = vis && (x_ptr == 10'(H_ACTIVE - 1)) && (&y_ptr[TILE_SHIFT-1:0]);

  // Reloaded whenever the raster sits at 0,0, which also covers the first
  // frame after reset when no frame_start pulse has been issued yet.
  always_ff @(posedge clk) begin
    if (!rst)
      row_base <= '0;
    else if (frame_origin)
      row_base <= page_tbl[cur_page];
    else if (row_step)
      row_base <= row_base + ADDR_W'(MAP_COLS);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      addrb <= '0;
    else
      addrb <= vis ? row_base + ADDR_W'(x_ptr >> TILE_SHIFT) : '0;
  end

  pipe_stage_t        pipe [RD_LAT+1];
  logic [COLOR_W-1:0] rgb_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= RST_STAGE;
    end else begin
      pipe[0] <= '{hs: raw_hs, vs: raw_vs, vis: vis};
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hs     <= POL;
      vs     <= POL;
      active <= 1'b0;
      rgb_q  <= '0;
    end else begin
      hs     <= pipe[RD_LAT].hs;
      vs     <= pipe[RD_LAT].vs;
      active <= pipe[RD_LAT].vis;
      rgb_q  <= pipe[RD_LAT].vis ? color : '0;
    end
  end

  assign red   = rgb_q[COLOR_W-1 -: C3];
  assign green = rgb_q[2*C3-1 -: C3];
  assign blue  = rgb_q[C3-1:0];

endmodule

// File: tb/tb_vga_tile_scanner.sv
// Self-checking bench for vga_tile_scanner: reduced raster, RAM model and a
// position-arithmetic reference model checked on every cycle.
module tb_vga_tile_scanner;
  import vga_tile_pkg::*;

  localparam int H_SYNC = 4, H_BP = 3, H_ACT = 16, H_FP = 2;
  localparam int V_SYNC = 2, V_BP = 2, V_ACT = 16, V_FP = 1;
  localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int HV0 = H_SYNC + H_BP, VV0 = V_SYNC + V_BP;
  localparam int TS = 2, MCOLS = 4, PBASE = 2048, PSTRIDE = 4800, RD_LAT = 2;
  localparam int HIST = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  page_req;
  logic        page_req_vld;
  color_t      color_a;
  logic [13:0] addrb;
  logic        hs, vs, active, frame_start;
  logic [3:0]  red, green, blue;
  logic [9:0]  x_ptr, y_ptr;
  logic [0:0]  cur_page;

  logic [0:0]  zero_page = '0;
  logic        zero_vld = 1'b0;
  color_t      color_b = 12'habc;
  logic [13:0] addrb_b;
  logic        hs_b, vs_b, active_b, frame_start_b;
  logic [3:0]  red_b, green_b, blue_b;
  logic [9:0]  x_ptr_b, y_ptr_b;
  logic [0:0]  cur_page_b;

  always #5 clk = ~clk;

  vga_tile_scanner #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACT), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACT), .V_FP(V_FP),
    .SYNC_POL(0), .TILE_SHIFT(TS), .MAP_COLS(MCOLS), .ADDR_W(14), .PAGE_W(1),
    .PAGE_BASE(PBASE), .PAGE_STRIDE(PSTRIDE), .RD_LAT(RD_LAT), .COLOR_W(12)
  ) dut (
    .clk(clk), .rst(rst), .page_req(page_req), .page_req_vld(page_req_vld),
    .color(color_a), .addrb(addrb), .hs(hs), .vs(vs), .red(red), .green(green),
    .blue(blue), .x_ptr(x_ptr), .y_ptr(y_ptr), .active(active),
    .frame_start(frame_start), .cur_page(cur_page)
  );

  vga_tile_scanner #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(32), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(32), .V_FP(1),
    .SYNC_POL(1), .TILE_SHIFT(3), .MAP_COLS(4), .ADDR_W(14), .PAGE_W(1),
    .PAGE_BASE(PBASE), .PAGE_STRIDE(PSTRIDE), .RD_LAT(1), .COLOR_W(12)
  ) dut_b (
    .clk(clk), .rst(rst), .page_req(zero_page), .page_req_vld(zero_vld),
    .color(color_b), .addrb(addrb_b), .hs(hs_b), .vs(vs_b), .red(red_b),
    .green(green_b), .blue(blue_b), .x_ptr(x_ptr_b), .y_ptr(y_ptr_b),
    .active(active_b), .frame_start(frame_start_b), .cur_page(cur_page_b)
  );

  logic [13:0] ram_q [RD_LAT];
  always @(posedge clk) begin
    ram_q[0] <= addrb;
    for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign color_a = ram_q[RD_LAT-1][11:0];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = clocks since the last reset edge; pages follow the
  // frame-boundary rule, addresses come from plain tile arithmetic.
  int k = 0, m_cur = 0, m_pend = 0;
  bit m_flag = 0, chk_en = 0;
  int page_hist [HIST];

  always @(posedge clk) begin
    if (!rst) begin
      k <= 0; m_cur <= 0; m_flag <= 0; chk_en <= 1;
    end else begin
      k <= k + 1;
      if (k % FRAME == FRAME - 1) begin
        if (page_req_vld) begin m_cur <= int'(page_req); m_flag <= 0; end
        else if (m_flag) begin m_cur <= m_pend; m_flag <= 0; end
      end else if (page_req_vld) begin
        m_pend <= int'(page_req); m_flag <= 1;
      end
    end
  end

  function automatic bit vis_at(input int st);
    int pos, x, y;
    pos = st % FRAME; x = pos % H_TOT; y = pos / H_TOT;
    return x >= HV0 && x < HV0 + H_ACT && y >= VV0 && y < VV0 + V_ACT;
  endfunction

  function automatic int addr_at(input int st);
    int pos, x, y;
    if (st < 0 || !vis_at(st)) return 0;
    pos = st % FRAME; x = pos % H_TOT; y = pos / H_TOT;
    return (PBASE + page_hist[st % HIST] * PSTRIDE
            + ((y - VV0) >> TS) * MCOLS + ((x - HV0) >> TS)) % 16384;
  endfunction

  int c_pos, c_d, e_hs, e_vs, e_act, e_rgb, e_addr, e_x, e_y, e_fs;

  always @(negedge clk) begin
    if (chk_en) begin
      page_hist[k % HIST] = m_cur;
      c_pos = k % FRAME;
      c_d   = k - (2 + RD_LAT);
      e_hs  = (c_d >= 0 && (c_d % FRAME) % H_TOT >= H_SYNC) ? 1 : 0;
      e_vs  = (c_d >= 0 && (c_d % FRAME) / H_TOT >= V_SYNC) ? 1 : 0;
      e_act = (c_d >= 0 && vis_at(c_d)) ? 1 : 0;
      e_rgb = e_act ? (addr_at(c_d) & 'hfff) : 0;
      e_addr = (k >= 1) ? addr_at(k - 1) : 0;
      e_x   = vis_at(k) ? c_pos % H_TOT - HV0 : 0;
      e_y   = vis_at(k) ? c_pos / H_TOT - VV0 : 0;
      e_fs  = (k > 0 && c_pos == 0) ? 1 : 0;
      chk("m_hs", int'(hs), e_hs);
      chk("m_vs", int'(vs), e_vs);
      chk("m_active", int'(active), e_act);
      chk("m_rgb", int'({red, green, blue}), e_rgb);
      chk("m_addrb", int'(addrb), e_addr);
      chk("m_x_ptr", int'(x_ptr), e_x);
      chk("m_y_ptr", int'(y_ptr), e_y);
      chk("m_frame_start", int'(frame_start), e_fs);
      chk("m_cur_page", int'(cur_page), m_cur);
    end
  end

  typedef struct {
    int x; int y; int exp_addr; int exp_page; int strobe;
  } vec_t;
  vec_t vt [7];

  task automatic wait_xy(input int x, input int y, output bit ok);
    ok = 0;
    for (int n = 0; n < 2 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (int'(x_ptr) == x && int'(y_ptr) == y) ok = 1;
    end
  endtask

  task automatic strobe(input int p);
    page_req = 1'(p); page_req_vld = 1'b1;
    @(negedge clk);
    page_req_vld = 1'b0;
  endtask

  bit b_done = 0;

  initial begin : b_checks
    int cnt, by [3], ba [3];
    bit ok;
    by = '{7, 8, 16}; ba = '{2048, 2052, 2056};
    wait (chk_en);
    @(negedge clk);
    chk("b_rst_hs_high", int'(hs_b), 1);
    chk("b_rst_vs_high", int'(vs_b), 1);
    wait (rst === 1'b1);
    repeat (100) @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 41; i++) begin
      @(negedge clk);
      if (hs_b) cnt++;
    end
    chk("b_hs_high_per_line", cnt, 4);
    for (int j = 0; j < 3; j++) begin
      ok = 0;
      for (int n = 0; n < 3100 && !ok; n++) begin
        @(negedge clk);
        if (int'(x_ptr_b) == 1 && int'(y_ptr_b) == by[j]) ok = 1;
      end
      chk("b_wait_xy", int'(ok), 1);
      @(negedge clk);
      chk("b_row_addrb", int'(addrb_b), ba[j]);
    end
    b_done = 1;
  end

  initial begin : main
    bit ok;
    int n;
    vt[0] = '{x: 1,  y: 0,  exp_addr: 2048, exp_page: 0, strobe: -1};
    vt[1] = '{x: 4,  y: 3,  exp_addr: 2049, exp_page: 0, strobe: -1};
    vt[2] = '{x: 3,  y: 4,  exp_addr: 2052, exp_page: 0, strobe: -1};
    vt[3] = '{x: 5,  y: 6,  exp_addr: 2053, exp_page: 0, strobe: -1};
    vt[4] = '{x: 15, y: 15, exp_addr: 2063, exp_page: 0, strobe: 1};
    vt[5] = '{x: 2,  y: 0,  exp_addr: 6848, exp_page: 1, strobe: -1};
    vt[6] = '{x: 15, y: 15, exp_addr: 6863, exp_page: 1, strobe: -1};

    rst = 1'b0; page_req = '0; page_req_vld = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addrb", int'(addrb), 0);
    chk("rst_hs_low", int'(hs), 0);
    chk("rst_active", int'(active), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wait_xy(vt[i].x, vt[i].y, ok);
      chk("tbl_wait_xy", int'(ok), 1);
      @(negedge clk);
      chk("tbl_addrb", int'(addrb), vt[i].exp_addr);
      chk("tbl_cur_page", int'(cur_page), vt[i].exp_page);
      if (vt[i].strobe >= 0) strobe(vt[i].strobe);
    end

    // Two strobes in one frame: the later one (page 0) wins.
    strobe(1);
    repeat (5) @(negedge clk);
    strobe(0);
    ok = 0;
    for (n = 0; n < 2 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (frame_start) ok = 1;
    end
    chk("two_strobe_wait", int'(ok), 1);
    chk("two_strobe_page", int'(cur_page), 0);

    // Strobe on the final frame clock takes effect on the very next frame.
    ok = 0;
    for (n = 0; n < 2 * FRAME && !ok; n++) begin
      @(negedge clk);
      if (k % FRAME == FRAME - 1) ok = 1;
    end
    chk("last_clk_wait", int'(ok), 1);
    page_req = 1'b1; page_req_vld = 1'b1;
    @(negedge clk);
    page_req_vld = 1'b0;
    chk("last_clk_page", int'(cur_page), 1);
    chk("last_clk_fs", int'(frame_start), 1);

    for (int i = 0; i < 1200; i++) begin
      page_req_vld = ($urandom_range(0, 40) == 0);
      page_req = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    page_req_vld = 1'b0;

    // Mid-frame reset with a pending request that must be dropped.
    wait_xy(3, 10, ok);
    chk("rst_wait_xy", int'(ok), 1);
    strobe(cur_page == 1'b1 ? 0 : 1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_addrb", int'(addrb), 0);
      chk("midrst_hs", int'(hs), 0);
      chk("midrst_vs", int'(vs), 0);
      chk("midrst_rgb", int'({red, green, blue}), 0);
      chk("midrst_page", int'(cur_page), 0);
      chk("midrst_fs", int'(frame_start), 0);
    end
    rst = 1'b1;
    ok = 0;
    n = 0;
    while (!ok && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
      if (frame_start) ok = 1;
    end
    chk("rst_frame_period", n, FRAME);
    chk("rst_dropped_page", int'(cur_page), 0);
    repeat (200) @(negedge clk);

    n = 0;
    while (!b_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("b_done", int'(b_done), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_chk, n_fail);
    $fatal(1);
  end

endmodule
